// File: rtl/yasac_pkg.sv
// Shared definitions for the yasac processor port peripherals:
// UART transmitter FSM states and port bit positions.
package yasac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // tx_ctrl (port01) bit positions
    localparam int CTRL_REQ     = 0;
    localparam int CTRL_PAR_EN  = 1;
    localparam int CTRL_PAR_ODD = 2;
    localparam int CTRL_CLR_OVR = 3;

    // tx_status (port08) bit positions
    localparam int STAT_ACK  = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVR  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable 16-bit down-counter pacing the serial bit period; bit_done
// pulses for one cycle when the current bit has lasted CLKS_PER_BIT cycles.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reload,
    output logic bit_done
);

    localparam logic [15:0] RELOAD_VAL = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (en && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = en && (cnt_q == 16'd0);

endmodule

// File: rtl/port_uart_tx.sv
// Port-mapped UART transmitter: toggle req/ack handshake on port01/port08,
// 8N1 or 8-bit-plus-parity framing, sticky overrun flag.
module port_uart_tx
    import yasac_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic [7:0] tx_ctrl,
    output logic [7:0] tx_status,
    output logic       tx
);

    tx_state_e  state_q,   state_d;
    logic [7:0] data_q,    data_d;
    logic       par_en_q,  par_en_d;
    logic       par_odd_q, par_odd_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tx_q,      tx_d;
    logic       ack_q,     ack_d;
    logic       busy_q,    busy_d;
    logic       ovr_q,     ovr_d;
    logic       req_prev_q;

    logic baud_en;
    logic baud_reload;
    logic bit_done;
    logic req_pending;
    logic req_toggled;
    logic parity_bit;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (reset),
        .en       (baud_en),
        .reload   (baud_reload),
        .bit_done (bit_done)
    );

    assign baud_en     = (state_q != ST_IDLE);
    assign req_pending = tx_ctrl[CTRL_REQ] ^ ack_q;
    assign req_toggled = tx_ctrl[CTRL_REQ] ^ req_prev_q;
    assign parity_bit  = (^data_q) ^ par_odd_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        bit_cnt_d   = bit_cnt_q;
        ack_d       = ack_q;
        baud_reload = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_pending) begin
                    state_d     = ST_START;
                    data_d      = tx_data;
                    par_en_d    = tx_ctrl[CTRL_PAR_EN];
                    par_odd_d   = tx_ctrl[CTRL_PAR_ODD];
                    bit_cnt_d   = 3'd0;
                    baud_reload = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d     = ST_DATA;
                    baud_reload = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_reload = 1'b1;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d     = ST_STOP;
                    baud_reload = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                    ack_d   = ~ack_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_cnt_d];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Clear wins over a toggle seen in the same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (tx_ctrl[CTRL_CLR_OVR]) begin
            ovr_d = 1'b0;
        end else if (req_toggled && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            data_q     <= 8'h00;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 1'b1;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            req_prev_q <= tx_ctrl[CTRL_REQ];
        end
    end

    assign tx = tx_q;

    always_comb begin
        tx_status            = 8'h00;
        tx_status[STAT_ACK]  = ack_q;
        tx_status[STAT_BUSY] = busy_q;
        tx_status[STAT_OVR]  = ovr_q;
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx at CLKS_PER_BIT=4 with hand-computed frames.
module tb_port_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic [7:0] tx_ctrl;
    logic [7:0] tx_status;
    logic       tx;

    int n_checks = 0;
    int n_pass   = 0;
    int mid_mode = 0;

    port_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_ctrl   (tx_ctrl),
        .tx_status (tx_status),
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input changes and checks made part-way through a frame, keyed by cycle index.
    task automatic apply_mid(input int c);
        case (mid_mode)
            1: begin
                if (c == 10) begin
                    tx_data    = 8'hFF;
                    tx_ctrl[2] = 1'b0;
                    tx_ctrl[1] = 1'b0;
                end
            end
            2: begin
                if (c == 8)  tx_ctrl[0] = 1'b1;
                if (c == 9)  tx_ctrl[0] = 1'b0;
                if (c == 12) check("ovr_set_mid", 32'(tx_status[2]), 32'd1);
            end
            3: begin
                if (c == 12) tx_ctrl = 8'h08;
                if (c == 13) begin
                    check("ovr_clr_beats_set", 32'(tx_status[2]), 32'd0);
                    tx_ctrl = 8'h00;
                end
                if (c == 14) begin
                    check("ovr_stays_clear", 32'(tx_status[2]), 32'd0);
                    tx_data = 8'h55;
                end
            end
            default: ;
        endcase
    endtask

    // Caller sets up a pending request; the first tick here is the accepting edge.
    task automatic run_frame(input string tag, input int nbits,
                             input logic [10:0] exp_bits, input logic exp_ack);
        logic [10:0] obs;
        int glitch;
        int busy_cnt;
        int ack_err;
        obs      = 11'd0;
        glitch   = 0;
        busy_cnt = 0;
        ack_err  = 0;
        tick();
        for (int c = 0; c < nbits * CPB; c++) begin
            if ((c % CPB) == 0) begin
                obs[c / CPB] = tx;
            end else if (tx !== obs[c / CPB]) begin
                glitch++;
            end
            if (tx_status[1] === 1'b1) busy_cnt++;
            if (tx_status[0] !== ~exp_ack) ack_err++;
            apply_mid(c);
            tick();
        end
        check({tag, "_bits"}, 32'(obs), 32'(exp_bits));
        check({tag, "_glitch"}, 32'(glitch), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(nbits * CPB));
        check({tag, "_ack_early"}, 32'(ack_err), 32'd0);
        check({tag, "_ack_after"}, 32'(tx_status[0]), 32'(exp_ack));
        check({tag, "_busy_after"}, 32'(tx_status[1]), 32'd0);
        check({tag, "_tx_idle"}, 32'(tx), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        tx_data = 8'h00;
        tx_ctrl = 8'h00;
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_status", 32'(tx_status), 32'h00);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_status", 32'(tx_status), 32'h00);

        // A5, no parity: 0,1,0,1,0,0,1,0,1,1
        tx_data = 8'hA5;
        tx_ctrl = 8'h01;
        run_frame("a5", 10, 11'h34A, 1'b1);
        check("a5_status", 32'(tx_status), 32'h01);
        repeat (3) tick();
        check("a5_no_refire", 32'(tx_status), 32'h01);

        // 07 even parity: parity bit 1
        tx_data = 8'h07;
        tx_ctrl = 8'h02;
        run_frame("p07_even", 11, 11'h60E, 1'b0);

        // 07 odd parity: parity bit 0; data/ctrl changed mid-frame
        tx_ctrl  = 8'h07;
        mid_mode = 1;
        run_frame("p07_odd", 11, 11'h40E, 1'b1);
        mid_mode = 0;

        // Double toggle while busy sets overrun, then a one-cycle clear
        tx_data  = 8'hA5;
        tx_ctrl  = 8'h00;
        mid_mode = 2;
        run_frame("ovr", 10, 11'h34A, 1'b0);
        mid_mode = 0;
        check("ovr_status", 32'(tx_status), 32'h04);
        tx_ctrl = 8'h08;
        tick();
        tx_ctrl = 8'h00;
        check("ovr_cleared", 32'(tx_status), 32'h00);

        // Clear beats toggle; leaves a pending 55 for back-to-back
        tx_data  = 8'hA5;
        tx_ctrl  = 8'h01;
        mid_mode = 3;
        run_frame("b2b_first", 10, 11'h34A, 1'b1);
        mid_mode = 0;
        check("b2b_ovr", 32'(tx_status[2]), 32'd0);
        run_frame("b2b_55", 10, 11'h2AA, 1'b0);
        check("b2b_status", 32'(tx_status), 32'h00);

        // Reset at cycle 15 of a frame of 00
        tx_data = 8'h00;
        tx_ctrl = 8'h01;
        tick();
        repeat (15) tick();
        check("pre_rst_tx", 32'(tx), 32'd0);
        check("pre_rst_busy", 32'(tx_status[1]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_status", 32'(tx_status), 32'h00);
        tx_ctrl = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_idle_status", 32'(tx_status), 32'h00);
        check("post_rst_idle_tx", 32'(tx), 32'd1);

        // Request level 1 through reset is accepted on the first edge
        reset   = 1'b1;
        tx_ctrl = 8'h01;
        tick();
        reset = 1'b0;
        run_frame("rst_pending", 10, 11'h200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
